// File: rtl/cache_pkg.sv
// cache_pkg: shared L1 cache command/trace encodings, MESI states and address field slices.
// Rev 1.0
`default_nettype none

package cache_pkg;

  localparam int ADDR_W    = 60;
  localparam int TAG_MSB   = 59;
  localparam int TAG_LSB   = 20;
  localparam int INDEX_MSB = 19;
  localparam int INDEX_LSB = 6;
  localparam int INDEX_W   = INDEX_MSB - INDEX_LSB + 1;
  localparam int BYTE_MSB  = 5;
  localparam int BYTE_LSB  = 0;

  typedef enum logic [2:0] {
    CMD_READ          = 3'd0,
    CMD_WRITE         = 3'd1,
    CMD_INVALIDATE    = 3'd2,
    CMD_CLEAR         = 3'd3,
    CMD_L2DATAREQUEST = 3'd4
  } cache_cmd_e;

  localparam logic [3:0] TRC_DATA_READ  = 4'd0;
  localparam logic [3:0] TRC_DATA_WRITE = 4'd1;
  localparam logic [3:0] TRC_IFETCH     = 4'd2;
  localparam logic [3:0] TRC_INVALIDATE = 4'd3;
  localparam logic [3:0] TRC_L2_REQ     = 4'd4;
  localparam logic [3:0] TRC_CLEAR      = 4'd8;
  localparam logic [3:0] TRC_PRINT_SET  = 4'd9;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    ACT_CMD  = 2'd0,
    ACT_DUMP = 2'd1,
    ACT_DROP = 2'd2
  } trace_action_e;

  typedef struct packed {
    trace_action_e action;
    cache_cmd_e    cmd;
  } trace_decode_t;

  function automatic trace_decode_t decode_trace(input logic [3:0] code);
    trace_decode_t d;
    d.action = ACT_CMD;
    d.cmd    = CMD_READ;
    case (code)
      TRC_DATA_READ:  d.cmd = CMD_READ;
      TRC_DATA_WRITE: d.cmd = CMD_WRITE;
      TRC_IFETCH:     d.cmd = CMD_READ;
      TRC_INVALIDATE: d.cmd = CMD_INVALIDATE;
      TRC_L2_REQ:     d.cmd = CMD_L2DATAREQUEST;
      TRC_CLEAR:      d.cmd = CMD_CLEAR;
      TRC_PRINT_SET:  d.action = ACT_DUMP;
      default:        d.action = ACT_DROP;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers for full/empty; head is the oldest entry.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/trace_dispatcher.sv
// trace_dispatcher: buffers trace entries and issues them to the L1 cache one command at a time.
// Rev 1.0
`default_nettype none

module trace_dispatcher
  import cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 60
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trace_valid,
  input  logic [3:0]    trace_code,
  input  logic [AW-1:0] trace_addr,
  output logic          trace_ready,
  output logic          cache_write,
  output logic [2:0]    cache_command,
  output logic [AW-1:0] cache_address,
  input  logic          cache_processing,
  output logic [13:0]   set_read,
  output logic          dump_req,
  output logic          idle,
  output logic [31:0]   issued_count,
  output logic [31:0]   dropped_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DUMP      = 3'd4
  } state_e;

  state_e        state;
  state_e        state_next;
  logic          full;
  logic          empty;
  logic          pop;
  logic [AW+3:0] head;
  logic [3:0]    head_code;
  logic [AW-1:0] head_addr;
  trace_decode_t dec;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (4 + AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (trace_valid),
    .pop   (pop),
    .din   ({trace_code, trace_addr}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign {head_code, head_addr} = head;
  assign dec         = decode_trace(head_code);
  assign trace_ready = !full;
  assign cache_write = (state == S_ISSUE);
  assign dump_req    = (state == S_DUMP);
  assign idle        = empty && (state == S_IDLE);

  // Pop only while the cache is quiet so at most one command is ever outstanding.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !cache_processing) begin
          pop = 1'b1;
          case (dec.action)
            ACT_CMD:  state_next = S_ISSUE;
            ACT_DUMP: state_next = S_DUMP;
            default:  state_next = S_IDLE;
          endcase
        end
      end
      S_ISSUE:     state_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (cache_processing) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!cache_processing) state_next = S_IDLE;
      S_DUMP:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cache_command <= '0;
      cache_address <= '0;
      set_read      <= '0;
      issued_count  <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        case (dec.action)
          ACT_CMD: begin
            cache_command <= dec.cmd;
            cache_address <= head_addr;
          end
          ACT_DUMP: set_read <= head_addr[INDEX_MSB:INDEX_LSB];
          default:  dropped_count <= dropped_count + 32'd1;
        endcase
      end
      if (state == S_ISSUE) issued_count <= issued_count + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trace_dispatcher.sv
// tb_trace_dispatcher: directed and random trace stimulus against a queue-based reference and cache model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_trace_dispatcher;

  localparam int DEPTH = 8;
  localparam int AW    = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trace_valid = 1'b0;
  logic [3:0]    trace_code = '0;
  logic [AW-1:0] trace_addr = '0;
  logic          trace_ready;
  logic          cache_write;
  logic [2:0]    cache_command;
  logic [AW-1:0] cache_address;
  logic          cache_processing = 1'b0;
  logic [13:0]   set_read;
  logic          dump_req;
  logic          idle;
  logic [31:0]   issued_count;
  logic [31:0]   dropped_count;

  always #5 clk = ~clk;

  trace_dispatcher #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .trace_valid      (trace_valid),
    .trace_code       (trace_code),
    .trace_addr       (trace_addr),
    .trace_ready      (trace_ready),
    .cache_write      (cache_write),
    .cache_command    (cache_command),
    .cache_address    (cache_address),
    .cache_processing (cache_processing),
    .set_read         (set_read),
    .dump_req         (dump_req),
    .idle             (idle),
    .issued_count     (issued_count),
    .dropped_count    (dropped_count)
  );

  // kind: 0 = cache command, 1 = set dump
  typedef struct {
    int            kind;
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   exp_issued = 0;
  int   exp_dropped = 0;
  int   strobes = 0;
  int   dumps = 0;
  int   busy = 0;
  bit   pend = 0;
  bit   hold_busy = 0;
  int   last_wr_cyc = 0;
  int   last_push_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int ref_kind(input logic [3:0] c);
    if (c <= 4 || c == 8) return 0;
    if (c == 9) return 1;
    return 2;
  endfunction

  function automatic logic [2:0] ref_cmd(input logic [3:0] c);
    case (c)
      4'd1:    return 3'd1;
      4'd3:    return 3'd2;
      4'd4:    return 3'd4;
      4'd8:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[AW-1:0];
  endfunction

  task automatic tick();
    exp_t e;
    if (trace_valid && trace_ready && !rst) begin
      last_push_cyc = cycle;
      e.kind = ref_kind(trace_code);
      e.cmd  = ref_cmd(trace_code);
      e.addr = trace_addr;
      e.cyc  = cycle;
      if (e.kind == 2) exp_dropped++;
      else expq.push_back(e);
    end
    @(posedge clk);
    #1;
    cycle++;
    if (cache_write) begin
      strobes++;
      last_wr_cyc = cycle;
      chk("write_while_busy", 64'(cache_processing), 64'd0);
      if (expq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        chk("write_kind", 64'(e.kind), 64'd0);
        chk("command", 64'(cache_command), 64'(e.cmd));
        chk("address", 64'(cache_address), 64'(e.addr));
        chk("latency_min", 64'((cycle - e.cyc) >= 2), 64'd1);
        exp_issued++;
      end
    end
    if (dump_req) begin
      dumps++;
      chk("dump_with_write", 64'(cache_write), 64'd0);
      if (expq.size() == 0) chk("unexpected_dump", 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        chk("dump_kind", 64'(e.kind), 64'd1);
        chk("set_read", 64'(set_read), 64'(e.addr[19:6]));
      end
    end
    // Cache model: busy starts the cycle after the strobe, lasts 1..4 cycles.
    if (busy > 0) busy--;
    if (pend) begin
      busy = $urandom_range(1, 4);
      pend = 0;
    end
    if (cache_write) pend = 1;
    cache_processing = hold_busy || (busy > 0);
  endtask

  task automatic offer(input logic [3:0] c, input logic [AW-1:0] a);
    bit ok;
    ok = 0;
    trace_valid = 1'b1;
    trace_code  = c;
    trace_addr  = a;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = trace_ready;
      tick();
    end
    trace_valid = 1'b0;
    if (!ok) chk("offer_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (idle && !cache_processing && busy == 0 && !pend) done = 1;
      else tick();
    end
    chk("idle_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    logic [AW-1:0] a;
    int            s0;
    int            d0;
    logic [3:0]    map_codes [5];
    logic [3:0]    cmd_codes [6];

    map_codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
    cmd_codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(trace_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_write", 64'(cache_write), 64'd0);
    chk("rst_dump", 64'(dump_req), 64'd0);
    chk("rst_cmd", 64'(cache_command), 64'd0);
    chk("rst_addr", 64'(cache_address), 64'd0);
    chk("rst_set", 64'(set_read), 64'd0);
    chk("rst_issued", 64'(issued_count), 64'd0);
    chk("rst_dropped", 64'(dropped_count), 64'd0);
    rst = 1'b0;
    tick();

    // Single read with minimum latency
    offer(4'd0, 60'h0000_0000_0123_440);
    wait_idle();
    chk("single_latency", 64'(last_wr_cyc - last_push_cyc), 64'd2);
    chk("single_issued", 64'(issued_count), 64'd1);
    chk("single_strobes", 64'(strobes), 64'd1);

    // Back-pressure: cache held busy, fill the FIFO, 9th is refused
    hold_busy = 1;
    cache_processing = 1'b1;
    for (int i = 0; i < DEPTH; i++) offer(cmd_codes[$urandom_range(0, 5)], rand_addr());
    chk("bp_full_ready", 64'(trace_ready), 64'd0);
    chk("bp_not_idle", 64'(idle), 64'd0);
    trace_valid = 1'b1;
    trace_code  = 4'd1;
    trace_addr  = rand_addr();
    for (int i = 0; i < 4; i++) begin
      chk("bp_refused", 64'(trace_ready), 64'd0);
      tick();
    end
    trace_valid = 1'b0;
    hold_busy = 0;
    wait_idle();
    chk("bp_issued", 64'(issued_count), 64'(exp_issued));
    chk("bp_strobes", 64'(strobes), 64'(1 + DEPTH));
    chk("bp_drained", 64'(expq.size()), 64'd0);

    // Code mapping sequence 1,2,3,4,8
    for (int i = 0; i < 5; i++) offer(map_codes[i], rand_addr());
    wait_idle();
    chk("map_issued", 64'(issued_count), 64'(exp_issued));

    // Unknown codes between two reads
    s0 = strobes;
    d0 = int'(dropped_count);
    offer(4'd0, rand_addr());
    offer(4'd5, rand_addr());
    offer(4'd6, rand_addr());
    offer(4'd7, rand_addr());
    offer(4'd0, rand_addr());
    wait_idle();
    chk("unk_dropped", 64'(int'(dropped_count) - d0), 64'd3);
    chk("unk_strobes", 64'(strobes - s0), 64'd2);
    chk("unk_issued", 64'(issued_count), 64'(exp_issued));

    // Set dump
    s0 = dumps;
    a = rand_addr();
    a[19:6] = 14'h2A5;
    offer(4'd9, a);
    wait_idle();
    chk("dump_set", 64'(set_read), 64'h2A5);
    chk("dump_count", 64'(dumps - s0), 64'd1);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      offer(4'($urandom_range(0, 15)), rand_addr());
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end
    wait_idle();
    chk("rnd_issued", 64'(issued_count), 64'(exp_issued));
    chk("rnd_dropped", 64'(dropped_count), 64'(exp_dropped));
    chk("rnd_drained", 64'(expq.size()), 64'd0);

    // Reset during WAIT_DONE with 3 entries queued
    s0 = strobes;
    offer(4'd1, rand_addr());
    for (int i = 0; i < 20 && strobes == s0; i++) tick();
    chk("mid_strobe_seen", 64'(strobes - s0), 64'd1);
    hold_busy = 1;
    for (int i = 0; i < 3; i++) offer(4'd0, rand_addr());
    tick();
    chk("mid_busy_not_idle", 64'(idle), 64'd0);
    rst = 1'b1;
    tick();
    expq.delete();
    exp_issued = 0;
    exp_dropped = 0;
    hold_busy = 0;
    busy = 0;
    pend = 0;
    cache_processing = 1'b0;
    chk("mid_rst_idle", 64'(idle), 64'd1);
    chk("mid_rst_ready", 64'(trace_ready), 64'd1);
    chk("mid_rst_issued", 64'(issued_count), 64'd0);
    chk("mid_rst_dropped", 64'(dropped_count), 64'd0);
    chk("mid_rst_write", 64'(cache_write), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'(idle), 64'd1);

    // Recovery after reset
    offer(4'd3, rand_addr());
    wait_idle();
    chk("post_rst_issued", 64'(issued_count), 64'd1);
    chk("final_idle", 64'(idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
